// File: rtl/summator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : summator_pkg
// Brief    : Shared sizing constants and result-slot state encoding for the
//            round-robin summator arbiter.
// Revision : 1.0  initial release
// ============================================================================
package summator_pkg;

  localparam int C_WIDTH = 17;
  localparam int C_NREQ  = 4;
  localparam int C_ID_W  = $clog2(C_NREQ);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage : summator_pkg
`default_nettype wire

// File: rtl/summator.sv
`default_nettype none
// ============================================================================
// Module   : summator
// Brief    : Combinational adder; operands are zero-extended so the result
//            carries the carry-out in its top bit.
// Revision : 1.0  initial release
// ============================================================================
module summator
  import summator_pkg::*;
#(
  parameter int WIDTH = C_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule : summator
`default_nettype wire

// File: rtl/summator_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : summator_arbiter
// Brief    : NREQ requesters share one adder through a round-robin arbiter;
//            a single registered result slot with valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module summator_arbiter
  import summator_pkg::*;
#(
  parameter  int NREQ  = C_NREQ,
  parameter  int WIDTH = C_WIDTH,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic                  res_carry,
  output logic [ID_W-1:0]       res_id
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic [WIDTH:0]  r_sum;
  logic [ID_W-1:0] w_win;
  logic            w_found;
  logic            w_slot_free;
  logic            w_xfer;
  logic [NREQ-1:0] w_grant;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]  w_sum;

  assign res_valid   = (r_state == ST_FULL);
  assign w_slot_free = !res_valid || res_ready;

  // Search starts at r_ptr and wraps; first asserted request wins.
  always_comb begin : arb_search
    int              idx;
    logic [ID_W-1:0] w_idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      w_idx = ID_W'(idx);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_xfer = w_found && w_slot_free;

  always_comb begin : grant_decode
    w_grant = '0;
    if (w_xfer) w_grant[w_win] = 1'b1;
  end

  // Gated by rst_n so no grant escapes while reset is held.
  assign req_ready = rst_n ? w_grant : '0;

  assign w_a = req_a[int'(w_win)*WIDTH +: WIDTH];
  assign w_b = req_b[int'(w_win)*WIDTH +: WIDTH];

  summator #(
    .WIDTH (WIDTH)
  ) u_summator (
    .a   (w_a),
    .b   (w_b),
    .sum (w_sum)
  );

  always_comb begin : fsm_next
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (res_ready && !w_xfer) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin : result_reg
    if (!rst_n) begin
      r_sum <= '0;
      r_id  <= '0;
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_sum <= w_sum;
      r_id  <= w_win;
      r_ptr <= (w_win == ID_W'(NREQ-1)) ? '0 : w_win + 1'b1;
    end
  end

  assign res_data  = r_sum[WIDTH-1:0];
  assign res_carry = r_sum[WIDTH];
  assign res_id    = r_id;

endmodule : summator_arbiter
`default_nettype wire

// File: tb/tb_summator_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_summator_arbiter
// Brief    : Scoreboard bench: stimulus pushes expected results from a
//            round-robin reference model, a monitor pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_summator_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 17;
  localparam int ID_W  = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic                  res_carry;
  logic [ID_W-1:0]       res_id;

  summator_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_id    (res_id)
  );

  typedef struct {
    longint sum;
    int     id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_ptr = 0;
  bit   m_full = 1'b0;
  bit   done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      default: v = WIDTH'($urandom);
    endcase
    return v;
  endfunction

  task automatic set_ops_random();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = rnd_op();
      req_b[i*WIDTH +: WIDTH] = rnd_op();
    end
  endtask

  // Called just after a rising edge; returns the model's winner (-1 if none).
  task automatic step(input logic [NREQ-1:0] v, input logic rr, output int gw);
    int               w;
    int               j;
    bit               xfer;
    logic [NREQ-1:0]  g;
    exp_t             e;
    req_valid = v;
    res_ready = rr;
    @(negedge clk);
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (w < 0 && v[j]) w = j;
    end
    xfer = (w >= 0) && (!m_full || rr);
    g = '0;
    if (xfer) g[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(g));
    if (xfer) begin
      e.sum = longint'(req_a[w*WIDTH +: WIDTH]) + longint'(req_b[w*WIDTH +: WIDTH]);
      e.id  = w;
      q.push_back(e);
      m_ptr = (w + 1) % NREQ;
    end
    @(posedge clk);
    #1;
    if (xfer)    m_full = 1'b1;
    else if (rr) m_full = 1'b0;
    gw = xfer ? w : -1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !done) begin
        chk("res_valid", 64'(res_valid), 64'(m_full));
        if (res_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL result_unexpected actual=id%0d required=none", res_id);
          end else begin
            e = q[0];
            chk("res_data", 64'(res_data), 64'(e.sum % (64'd1 << WIDTH)));
            chk("res_carry", 64'(res_carry), 64'(e.sum >> WIDTH));
            chk("res_id", 64'(res_id), 64'(e.id));
            if (res_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_data"},  64'(res_data),  64'd0);
    chk({tag, "_carry"}, 64'(res_carry), 64'd0);
    chk({tag, "_id"},    64'(res_id),    64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
  endtask

  initial begin : stimulus
    int               gw;
    logic [WIDTH-1:0] held;
    int               fair_exp[5];
    fair_exp = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request on requester 0.
    req_a[0 +: WIDTH] = 17'd5;
    req_b[0 +: WIDTH] = 17'd7;
    step(4'b0001, 1'b1, gw);
    chk("single_grant", 64'(gw), 64'd0);
    chk("single_valid", 64'(res_valid), 64'd1);
    chk("single_data", 64'(res_data), 64'd12);
    chk("single_carry", 64'(res_carry), 64'd0);
    chk("single_id", 64'(res_id), 64'd0);

    // Overflow on requester 1.
    req_a[WIDTH +: WIDTH] = 17'h1FFFF;
    req_b[WIDTH +: WIDTH] = 17'h00002;
    step(4'b0010, 1'b1, gw);
    chk("ovf_data", 64'(res_data), 64'h1);
    chk("ovf_carry", 64'(res_carry), 64'd1);

    // Reset between edges with a held result and ptr=2.
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    q.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness from a fresh pointer.
    set_ops_random();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, gw);
      chk("fair_grant", 64'(gw), 64'(fair_exp[i]));
      chk("fair_valid", 64'(res_valid), 64'd1);
    end

    // Backpressure: requester 1 waits while the slot is held.
    held = res_data;
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 1'b0, gw);
      chk("bp_nogrant", 64'(gw), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("bp_stable", 64'(res_data), 64'(held));
    end
    step(4'b0010, 1'b1, gw);
    chk("bp_accept", 64'(gw), 64'd1);

    // Withdrawal: requester 2 drops out while stalled.
    step(4'b0100, 1'b0, gw);
    chk("wd_nogrant", 64'(gw), 64'hFFFF_FFFF_FFFF_FFFF);
    step(4'b0001, 1'b1, gw);
    chk("wd_grant0", 64'(gw), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) set_ops_random();
      step(NREQ'($urandom), ($urandom_range(0, 3) != 0), gw);
    end

    step('0, 1'b1, gw);
    step('0, 1'b1, gw);
    chk("drain_empty", 64'(q.size()), 64'd0);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_summator_arbiter
`default_nettype wire
